// File: rtl/i2c_axil_pkg.sv
//------------------------------------------------------------------------------
// Module  : i2c_axil_pkg
// Brief   : Register map constants shared by the I2C AXI4-Lite register block.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package i2c_axil_pkg;

   localparam int          IDX_W       = 2;
   localparam int          NUM_REGS    = 4;
   localparam logic [3:0]  REG0_OFFSET = 4'h0;
   localparam logic [3:0]  REG1_OFFSET = 4'h4;
   localparam logic [3:0]  REG2_OFFSET = 4'h8;
   localparam logic [3:0]  REG3_OFFSET = 4'hC;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [31:0] REG_RESET   = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/i2c_axil_regs.sv
//------------------------------------------------------------------------------
// Module  : i2c_axil_regs
// Brief   : AXI4-Lite slave exposing four 32-bit control registers to the I2C core.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module i2c_axil_regs
   import i2c_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o,
   output logic [NUM_REGS-1:0]               wr_pulse_o
);

   localparam int C_NBYTES = C_S_AXI_DATA_WIDTH / 8;

   logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] r_regs;

   // Readies stay low until the first edge after reset release.
   logic                          r_live;
   logic                          r_aw_held;
   logic [IDX_W-1:0]              r_aw_idx;
   logic                          r_w_held;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_w_data;
   logic [C_NBYTES-1:0]           r_w_strb;
   logic                          r_bvalid;
   logic [1:0]                    r_bresp;
   logic [NUM_REGS-1:0]           r_wr_pulse;
   logic                          r_rvalid;
   logic [1:0]                    r_rresp;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

   logic                          w_awready;
   logic                          w_wready;
   logic                          w_arready;
   logic                          w_aw_hs;
   logic                          w_w_hs;
   logic                          w_ar_hs;
   logic                          w_commit;
   logic [IDX_W-1:0]              w_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
   logic [C_NBYTES-1:0]           w_strb;
   logic                          w_unused_bits;

   assign w_awready = r_live & ~r_aw_held & ~r_bvalid;
   assign w_wready  = r_live & ~r_w_held  & ~r_bvalid;
   assign w_arready = r_live & ~r_rvalid;

   assign w_aw_hs  = S_AXI_AWVALID & w_awready;
   assign w_w_hs   = S_AXI_WVALID  & w_wready;
   assign w_ar_hs  = S_AXI_ARVALID & w_arready;
   assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

   // Held payload takes priority; otherwise the live handshake supplies it.
   assign w_idx  = r_aw_held ? r_aw_idx : S_AXI_AWADDR[3:2];
   assign w_data = r_w_held  ? r_w_data : S_AXI_WDATA;
   assign w_strb = r_w_held  ? r_w_strb : S_AXI_WSTRB;

   assign w_unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) r_live <= 1'b0;
      else          r_live <= 1'b1;
   end

   // Write path: hold AW/W independently, commit once both are present.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_regs     <= {NUM_REGS{REG_RESET}};
         r_aw_held  <= 1'b0;
         r_aw_idx   <= '0;
         r_w_held   <= 1'b0;
         r_w_data   <= '0;
         r_w_strb   <= '0;
         r_bvalid   <= 1'b0;
         r_bresp    <= '0;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= '0;
         if (w_commit) begin
            for (int b = 0; b < C_NBYTES; b++) begin
               if (w_strb[b]) r_regs[w_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
            r_wr_pulse <= NUM_REGS'(1) << w_idx;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_bvalid   <= 1'b1;
            r_bresp    <= RESP_OKAY;
         end else begin
            if (w_aw_hs) begin
               r_aw_held <= 1'b1;
               r_aw_idx  <= S_AXI_AWADDR[3:2];
            end
            if (w_w_hs) begin
               r_w_held <= 1'b1;
               r_w_data <= S_AXI_WDATA;
               r_w_strb <= S_AXI_WSTRB;
            end
            if (r_bvalid && S_AXI_BREADY) r_bvalid <= 1'b0;
         end
      end
   end

   // Read path samples r_regs before any same-edge write lands.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_rvalid <= 1'b0;
         r_rresp  <= '0;
         r_rdata  <= '0;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rresp  <= RESP_OKAY;
         r_rdata  <= r_regs[S_AXI_ARADDR[3:2]];
      end else if (r_rvalid && S_AXI_RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

   assign S_AXI_AWREADY = w_awready;
   assign S_AXI_WREADY  = w_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = w_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RRESP   = r_rresp;
   assign S_AXI_RDATA   = r_rdata;
   assign reg0_o        = r_regs[0];
   assign reg1_o        = r_regs[1];
   assign reg2_o        = r_regs[2];
   assign reg3_o        = r_regs[3];
   assign wr_pulse_o    = r_wr_pulse;

endmodule

`default_nettype wire

// File: tb/tb_i2c_axil_regs.sv
//------------------------------------------------------------------------------
// Module  : tb_i2c_axil_regs
// Brief   : Directed self-checking bench for the I2C AXI4-Lite register block.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2c_axil_regs;
   import i2c_axil_pkg::*;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [3:0]  S_AXI_AWADDR = '0;
   logic [2:0]  S_AXI_AWPROT = '0;
   logic        S_AXI_AWVALID = 1'b0;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA = '0;
   logic [3:0]  S_AXI_WSTRB = '0;
   logic        S_AXI_WVALID = 1'b0;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY = 1'b0;
   logic [3:0]  S_AXI_ARADDR = '0;
   logic [2:0]  S_AXI_ARPROT = '0;
   logic        S_AXI_ARVALID = 1'b0;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY = 1'b0;
   logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;
   logic [3:0]  wr_pulse_o;

   int n_cmp = 0;
   int n_err = 0;

   i2c_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) u_dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
      .wr_pulse_o(wr_pulse_o)
   );

   always #5 ACLK = ~ACLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Full write with AW and W presented together, then B handshake.
   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int t = 0;
      S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      while (!(S_AXI_AWREADY && S_AXI_WREADY) && t < 20) begin tick(); t++; end
      if (t >= 20) check_eq("wr_ready_timeout", {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h3);
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      check_eq("wr_bvalid", {31'b0, S_AXI_BVALID}, 32'h1);
      check_eq("wr_bresp", {30'b0, S_AXI_BRESP}, {30'b0, RESP_OKAY});
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
      int t = 0;
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
      while (!S_AXI_ARREADY && t < 20) begin tick(); t++; end
      if (t >= 20) check_eq("rd_ready_timeout", {31'b0, S_AXI_ARREADY}, 32'h1);
      tick();
      S_AXI_ARVALID = 1'b0;
      check_eq("rd_rvalid", {31'b0, S_AXI_RVALID}, 32'h1);
      check_eq("rd_rresp", {30'b0, S_AXI_RRESP}, {30'b0, RESP_OKAY});
      d = S_AXI_RDATA;
      S_AXI_RREADY = 1'b1;
      tick();
      S_AXI_RREADY = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [3:0]  addrs [4];
      addrs[0] = REG0_OFFSET; addrs[1] = REG1_OFFSET;
      addrs[2] = REG2_OFFSET; addrs[3] = REG3_OFFSET;

      // Reset state and first ready assertion
      repeat (3) tick();
      check_eq("rst_awready", {31'b0, S_AXI_AWREADY}, 32'h0);
      check_eq("rst_arready", {31'b0, S_AXI_ARREADY}, 32'h0);
      check_eq("rst_reg0", reg0_o, 32'h0);
      ARESETN = 1'b1;
      @(negedge ACLK);
      check_eq("rel_awready_early", {31'b0, S_AXI_AWREADY}, 32'h0);
      tick();
      check_eq("rel_awready", {31'b0, S_AXI_AWREADY}, 32'h1);
      check_eq("rel_wready", {31'b0, S_AXI_WREADY}, 32'h1);
      check_eq("rel_arready", {31'b0, S_AXI_ARREADY}, 32'h1);

      // Four writes then four reads
      for (int i = 0; i < 4; i++) axi_write(addrs[i], 32'(i + 1), 4'hF);
      for (int i = 0; i < 4; i++) begin
         axi_read(addrs[i], rd);
         check_eq($sformatf("rd_reg%0d", i), rd, 32'(i + 1));
      end

      // W three cycles ahead of AW to 0x8
      S_AXI_WDATA = 32'hA5A5_A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_WVALID = 1'b0;
      check_eq("wfirst_wready_low", {31'b0, S_AXI_WREADY}, 32'h0);
      check_eq("wfirst_no_commit", {28'b0, wr_pulse_o}, 32'h0);
      tick(); tick();
      check_eq("wfirst_bvalid_idle", {31'b0, S_AXI_BVALID}, 32'h0);
      S_AXI_AWADDR = REG2_OFFSET; S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      check_eq("wfirst_bvalid", {31'b0, S_AXI_BVALID}, 32'h1);
      check_eq("wfirst_pulse", {28'b0, wr_pulse_o}, 32'h4);
      check_eq("wfirst_reg2", reg2_o, 32'hA5A5_A5A5);
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      check_eq("wfirst_pulse_gone", {28'b0, wr_pulse_o}, 32'h0);

      // Byte strobes
      axi_write(REG1_OFFSET, 32'hFFFF_FFFF, 4'hF);
      axi_write(REG1_OFFSET, 32'h1234_5678, 4'b0101);
      check_eq("strb_reg1", reg1_o, 32'hFF34_FF78);

      // WSTRB=0000 still pulses without changing the register
      S_AXI_AWADDR = REG3_OFFSET; S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'h0;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      check_eq("strb0_pulse", {28'b0, wr_pulse_o}, 32'h8);
      check_eq("strb0_reg3", reg3_o, 32'h4);
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;

      // BREADY held low with a second write pending
      S_AXI_AWADDR = REG3_OFFSET; S_AXI_WDATA = 32'h0000_0077; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_AWADDR = REG0_OFFSET; S_AXI_WDATA = 32'h0000_0001;
      for (int c = 0; c < 5; c++) begin
         check_eq("bhold_bvalid", {31'b0, S_AXI_BVALID}, 32'h1);
         check_eq("bhold_readies", {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h0);
         tick();
      end
      check_eq("bhold_reg0_kept", reg0_o, 32'h1);
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      check_eq("bhold_bvalid_clr", {31'b0, S_AXI_BVALID}, 32'h0);
      check_eq("bhold_awready_back", {31'b0, S_AXI_AWREADY}, 32'h1);
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      check_eq("bhold_second_pulse", {28'b0, wr_pulse_o}, 32'h1);
      check_eq("bhold_reg3", reg3_o, 32'h77);
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;

      // Same-edge read and write to register 0
      S_AXI_AWADDR = REG0_OFFSET; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      S_AXI_ARADDR = REG0_OFFSET; S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      check_eq("rw_rvalid", {31'b0, S_AXI_RVALID}, 32'h1);
      check_eq("rw_old_data", S_AXI_RDATA, 32'h1);
      check_eq("rw_reg0_new", reg0_o, 32'h55);
      S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
      axi_read(REG0_OFFSET, rd);
      check_eq("rw_new_data", rd, 32'h55);

      // Reset with both responses pending
      S_AXI_AWADDR = REG1_OFFSET; S_AXI_WDATA = 32'h3; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      S_AXI_ARADDR = REG2_OFFSET; S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      check_eq("prerst_valids", {30'b0, S_AXI_BVALID, S_AXI_RVALID}, 32'h3);
      #2 ARESETN = 1'b0;
      #1;
      check_eq("arst_valids", {30'b0, S_AXI_BVALID, S_AXI_RVALID}, 32'h0);
      check_eq("arst_regs_or", reg0_o | reg1_o | reg2_o | reg3_o, 32'h0);
      check_eq("arst_rdata", S_AXI_RDATA, 32'h0);
      tick();
      ARESETN = 1'b1;
      tick();
      check_eq("rerel_readies", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);
      axi_read(REG1_OFFSET, rd);
      check_eq("rerel_reg1", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
